// File: rtl/sa_stream_host.sv
// Host-side initiator for SA_core: collects a job on an input stream, runs the core,
// then streams the captured result matrix row-major on an output stream.
module sa_stream_host #(
  parameter int unsigned N       = 3,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ACC     = 32,
  parameter int unsigned SETTLE  = 2 * N,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [WIDTH-1:0]        in_data,
  output logic                           core_start,
  input  logic                           core_done,
  output logic [N-1:0][N-1:0][WIDTH-1:0] A_mem,
  output logic [N-1:0][N-1:0][WIDTH-1:0] B_mem,
  input  logic [N-1:0][N-1:0][ACC-1:0]   C_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [ACC-1:0]          out_data,
  output logic                           out_last,
  output logic                           busy,
  output logic                           timeout
);

  localparam int unsigned RW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CMAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_START,
    S_WAIT,
    S_SETTLE,
    S_DRAIN
  } state_t;

  state_t                         state, state_n;
  logic [RW-1:0]                  row, row_n, col, col_n;
  logic                           half, half_n;
  logic [CW-1:0]                  cnt, cnt_n;
  logic                           timeout_n;
  logic                           done_q;
  logic                           cap, load_we;
  logic [N-1:0][N-1:0][ACC-1:0]   res, res_n;
  logic                           in_ready_d, core_start_d, busy_d, out_valid_d, out_last_d;
  logic [ACC-1:0]                 out_data_d;
  logic                           in_hs, out_hs, step, last_pos, done_rise;

  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign step      = in_hs || out_hs;
  assign last_pos  = (row == RW'(N - 1)) && (col == RW'(N - 1));
  assign done_rise = core_done && !done_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LOAD;
    else        state <= state_n;
  end

  // Next-state and counter logic; row/col walk the matrix for both loading and draining
  always_comb begin
    state_n   = state;
    row_n     = row;
    col_n     = col;
    half_n    = half;
    cnt_n     = cnt;
    timeout_n = timeout;
    cap       = 1'b0;
    load_we   = 1'b0;

    if (step) begin
      if (col == RW'(N - 1)) begin
        col_n = '0;
        row_n = last_pos ? '0 : row + RW'(1);
      end else begin
        col_n = col + RW'(1);
      end
    end

    unique case (state)
      S_LOAD: begin
        if (in_hs) begin
          load_we = 1'b1;
          if (last_pos) begin
            half_n = ~half;
            if (half) begin
              state_n   = S_START;
              cnt_n     = '0;
              timeout_n = 1'b0;
            end
          end
        end
      end
      S_START: state_n = S_WAIT;
      S_WAIT: begin
        if (done_rise) begin
          state_n = S_SETTLE;
          cnt_n   = '0;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          timeout_n = 1'b1;
          state_n   = S_LOAD;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_SETTLE: begin
        if (cnt == CW'(SETTLE - 1)) begin
          cap     = 1'b1;
          state_n = S_DRAIN;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DRAIN: begin
        if (out_hs && last_pos) state_n = S_LOAD;
      end
      default: state_n = S_LOAD;
    endcase
  end

  // Output decode from the next state so every port comes straight from a flop
  always_comb begin
    res_n        = cap ? C_in : res;
    in_ready_d   = (state_n == S_LOAD);
    core_start_d = (state_n == S_START);
    busy_d       = (state_n != S_LOAD);
    out_valid_d  = (state_n == S_DRAIN);
    out_last_d   = out_valid_d && (row_n == RW'(N - 1)) && (col_n == RW'(N - 1));
    out_data_d   = res_n[row_n][col_n];
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row        <= '0;
      col        <= '0;
      half       <= 1'b0;
      cnt        <= '0;
      timeout    <= 1'b0;
      done_q     <= 1'b0;
      A_mem      <= '0;
      B_mem      <= '0;
      res        <= '0;
      in_ready   <= 1'b1;
      core_start <= 1'b0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
    end else begin
      row        <= row_n;
      col        <= col_n;
      half       <= half_n;
      cnt        <= cnt_n;
      timeout    <= timeout_n;
      done_q     <= core_done;
      res        <= res_n;
      if (load_we) begin
        if (half) B_mem[row][col] <= in_data;
        else      A_mem[row][col] <= in_data;
      end
      in_ready   <= in_ready_d;
      core_start <= core_start_d;
      busy       <= busy_d;
      out_valid  <= out_valid_d;
      out_last   <= out_last_d;
      out_data   <= out_data_d;
    end
  end

endmodule

// File: doc/sa_stream_host.md
Name: sa_stream_host

Overview:
- Host-side initiator for SA_core. Drives the core's start/done/A_mem/B_mem/C_out interface.
- Accepts one job on a valid/ready input stream: 2*N*N signed WIDTH-bit elements, A row-major then B row-major.
- Loads the job into the operand registers, pulses start, waits for done, then captures C.
- Streams C row-major on a valid/ready output stream. Replaces bench-driven matrix loading in system integration.

Parameters:
- N, 3, matrix dimension.
- WIDTH, 8, signed operand width.
- ACC, 32, signed result width.
- SETTLE, 2*N, cycles waited after the done rising edge before C is captured.
- TIMEOUT, 1024, maximum cycles in WAIT before the job is aborted.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  input element accepted when in_valid && in_ready.
- in_data  in  WIDTH  signed input element.
- core_start  out  1  start pulse to SA_core.
- core_done  in  1  done from SA_core.
- A_mem  out  [N][N] x WIDTH  operand A to core.
- B_mem  out  [N][N] x WIDTH  operand B to core.
- C_in  in  [N][N] x ACC  result from core (its C_out).
- out_valid  out  1  result element valid.
- out_ready  in  1  result element consumed when out_valid && out_ready.
- out_data  out  ACC  signed result element.
- out_last  out  1  high with element N*N-1.
- busy  out  1  high in any state other than LOAD.
- timeout  out  1  sticky abort flag.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State LOAD, index 0.
  - A_mem, B_mem and the result buffer all zero; done_q=0.
  - Outputs: core_start=0, out_valid=0, out_last=0, busy=0, timeout=0, in_ready=1 once rst_n=1.
  - Reset mid-job aborts immediately with no partial output.
- LOAD:
  - in_ready=1.
  - Each handshake writes element k (0..2N*N-1): k<N*N goes to A_mem[k/N][k%N]; otherwise to B_mem[(k-N*N)/N][(k-N*N)%N].
  - On the handshake with k=2N*N-1, go to START. The index returns to 0.
- START:
  - Lasts 1 cycle with core_start=1, then go to WAIT.
  - Clear timeout on entry; clear the cycle counter.
  - in_ready=0 in every state except LOAD.
- WAIT:
  - done_q registers core_done every cycle.
  - Advance only on a rising edge (core_done=1 && done_q=0). A done level held high from the previous job is ignored until it drops.
  - Rising edge: go to SETTLE, counter cleared.
  - Counter reaching TIMEOUT-1 with no edge: set timeout=1 and go to LOAD. No output is produced.
- SETTLE:
  - Count SETTLE cycles. In the last cycle, register C_in into the result buffer, then go to DRAIN.
- DRAIN:
  - out_valid=1; out_data = buffer[idx/N][idx%N]; out_last = (idx==N*N-1).
  - idx increments on each handshake. out_data is stable while out_valid && !out_ready.
  - Handshake with out_last: go to LOAD, out_valid=0 next cycle.
- Operand stability:
  - A_mem/B_mem hold their values from the end of LOAD until overwritten during the next LOAD.
  - C_in is sampled only in the final SETTLE cycle.
- Arithmetic: none; the data path is pure storage. Signed values pass through bit-exact.
- Simultaneous events:
  - core_done activity outside WAIT is ignored, but done_q still tracks it.
  - Input handshakes cannot occur outside LOAD.
- Minimum job latency from the last input handshake to the first out_valid: 1 (START) + edge detect + SETTLE + 1 cycles.

Test Plan:
- N=3, A=identity, B=1..9, model core with done edge 5 cycles after start -> out_data 1,2,...,9, out_last only on the 9th, core_start high exactly 1 cycle.
- A all -4, B all 4 -> nine outputs of -48, each equal to C_in, sign preserved through ACC=32.
- Random out_ready (about 50%) on the previous job -> all 9 values in order, no duplicates/drops, out_data stable during stalls, in_ready=0 until the last handshake.
- core_done stuck high from before start -> no progress. Done drops and then rises -> normal completion after SETTLE=6 cycles.
- TIMEOUT=16, core_done never rises -> timeout=1 16 cycles after START, state LOAD, in_ready=1, no out_valid. Next job's START clears timeout.
- rst_n low after 5 input handshakes -> A_mem all 0, index 0. A fresh 18-element job then produces correct results.
